// File: rtl/noc_input_port.sv
// Router input stage: drains the read side of a port's async FIFO into a
// 3-entry queue, computes the XY route per packet and offers flits to the allocator.
module noc_input_port #(
  parameter int DATA_WIDTH = 32,
  parameter int LOCAL_X    = 0,
  parameter int LOCAL_Y    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [4:0]            out_dir,
  output logic                  out_head,
  output logic                  out_tail,
  output logic                  pkt_active,
  output logic                  err_orphan
);

  localparam logic [1:0] TYPE_HEAD   = 2'b10;
  localparam logic [1:0] TYPE_TAIL   = 2'b01;
  localparam logic [1:0] TYPE_SINGLE = 2'b11;

  localparam logic [4:0] DIR_LOCAL = 5'b10000;
  localparam logic [4:0] DIR_W     = 5'b01000;
  localparam logic [4:0] DIR_S     = 5'b00100;
  localparam logic [4:0] DIR_E     = 5'b00010;
  localparam logic [4:0] DIR_N     = 5'b00001;

  localparam logic [1:0] LX = 2'(LOCAL_X);
  localparam logic       LY = 1'(LOCAL_Y);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] queue      [3];
  logic [DATA_WIDTH-1:0] queue_next [3];
  logic [1:0]            count;
  logic                  inflight;
  logic [4:0]            route_reg;

  logic [DATA_WIDTH-1:0] head_flit;
  logic [1:0]            head_type;
  logic                  head_is_start;
  logic [4:0]            head_route;
  logic                  has_flit;
  logic                  drop;
  logic                  accept;
  logic                  pop;
  logic [1:0]            wr_idx;

  function automatic logic [4:0] xy_route(input logic [1:0] dx, input logic dy);
    if (dx > LX)      return DIR_E;
    else if (dx < LX) return DIR_W;
    else if (dy > LY) return DIR_S;
    else if (dy < LY) return DIR_N;
    else              return DIR_LOCAL;
  endfunction

  assign head_flit     = queue[0];
  assign head_type     = head_flit[DATA_WIDTH-1:DATA_WIDTH-2];
  assign head_is_start = head_type[1];
  assign head_route    = xy_route(head_flit[DATA_WIDTH-3:DATA_WIDTH-4], head_flit[DATA_WIDTH-5]);
  assign has_flit      = (count != 2'd0);
  assign pkt_active    = (state == ACTIVE);

  // A body/tail reaching the queue head with no packet open is thrown away.
  always_comb begin
    drop       = has_flit && (state == IDLE) && !head_is_start;
    out_valid  = has_flit && !drop;
    accept     = out_valid && out_ready;
    pop        = accept || drop;
    err_orphan = drop;
    out_data   = out_valid ? head_flit : '0;
    out_dir    = 5'b0;
    out_head   = 1'b0;
    out_tail   = 1'b0;
    if (out_valid) begin
      if (state == ACTIVE) begin
        out_dir  = route_reg;
        out_tail = (head_type == TYPE_TAIL);
      end else begin
        out_dir  = head_route;
        out_head = 1'b1;
        out_tail = (head_type == TYPE_SINGLE);
      end
    end
  end

  // Counting in-flight reads guarantees room for every requested word.
  assign rd_en = !rst && !empty && (({1'b0, count} + {2'b0, inflight}) < 3'd3);

  always_comb begin
    queue_next = queue;
    wr_idx     = count - {1'b0, pop};
    if (pop) begin
      queue_next[0] = queue[1];
      queue_next[1] = queue[2];
    end
    if (inflight) begin
      case (wr_idx)
        2'd0:    queue_next[0] = rd_data;
        2'd1:    queue_next[1] = rd_data;
        default: queue_next[2] = rd_data;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) queue[i] <= '0;
      count     <= 2'd0;
      inflight  <= 1'b0;
      state     <= IDLE;
      route_reg <= 5'b0;
    end else begin
      for (int i = 0; i < 3; i++) queue[i] <= queue_next[i];
      count    <= count + {1'b0, inflight} - {1'b0, pop};
      inflight <= rd_en;
      case (state)
        IDLE: begin
          if (accept && head_type == TYPE_HEAD) begin
            state     <= ACTIVE;
            route_reg <= head_route;
          end
        end
        ACTIVE: begin
          if (accept && head_type == TYPE_TAIL) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_input_port.sv
// Self-checking bench for noc_input_port (LOCAL_X=1, LOCAL_Y=0) with a FIFO model
// and a packet-level reference model of the expected output stream.
module tb_noc_input_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en;
  logic [31:0] rd_data = '0;
  logic        empty = 1'b1;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_dir;
  logic        out_head;
  logic        out_tail;
  logic        pkt_active;
  logic        err_orphan;

  noc_input_port #(.DATA_WIDTH(32), .LOCAL_X(1), .LOCAL_Y(0)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dir(out_dir), .out_head(out_head), .out_tail(out_tail),
    .pkt_active(pkt_active), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dir;
    logic        head;
    logic        tail;
  } exp_t;

  typedef struct {
    logic [31:0] flit;
    logic [4:0]  dir;
    logic        head;
    logic        tail;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] fifo_q[$];
  int          n_compared = 0;
  int          n_failed = 0;
  int          cyc = 0;
  int          accepted = 0;
  int          orphans_seen = 0;
  int          popped = 0;
  int          m_orphans = 0;
  bit          m_active = 0;
  logic [4:0]  m_route = '0;
  bit          stall_valid = 0;
  logic [31:0] stall_data = '0;
  logic [4:0]  stall_dir = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // XY routing as stated: X first, then Y; this router is (1,0).
  function automatic logic [4:0] ref_route(input logic [31:0] f);
    int x = int'(f[29:28]);
    int y = int'(f[27]);
    if (x > 1)      return 5'b00010;
    else if (x < 1) return 5'b01000;
    else if (y > 0) return 5'b00100;
    else if (y < 0) return 5'b00001;
    else            return 5'b10000;
  endfunction

  task automatic model_flit(input logic [31:0] f);
    exp_t e;
    logic [1:0] t = f[31:30];
    if (!m_active) begin
      if (t == 2'b10 || t == 2'b11) begin
        e = '{data: f, dir: ref_route(f), head: 1'b1, tail: (t == 2'b11)};
        exp_q.push_back(e);
        if (t == 2'b10) begin
          m_active = 1;
          m_route  = ref_route(f);
        end
      end else begin
        m_orphans++;
      end
    end else begin
      e = '{data: f, dir: m_route, head: 1'b0, tail: (t == 2'b01)};
      exp_q.push_back(e);
      if (t == 2'b01) m_active = 0;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] f);
    fifo_q.push_back(f);
    model_flit(f);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FIFO read side: data appears the cycle after rd_en, empty is registered.
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      empty <= 1'b1;
    end else begin
      if (rd_en) begin
        if (fifo_q.size() > 0) begin
          rd_data <= fifo_q.pop_front();
          popped++;
        end else begin
          checkOutput("rd_en_on_empty", 64'(rd_en), 64'd0);
        end
      end
      empty <= (fifo_q.size() == 0);
    end
  end

  // Output monitor: every accepted flit is compared against the model stream.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (err_orphan) orphans_seen++;
      if (stall_valid)
        checkOutput("hold", {out_valid, out_data, out_dir}, {1'b1, stall_data, stall_dir});
      stall_valid = out_valid && !out_ready;
      stall_data  = out_data;
      stall_dir   = out_dir;
      if (out_valid && out_ready) begin
        accepted++;
        if (exp_q.size() == 0) begin
          checkOutput("accept_unexpected", {out_data, out_dir}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("accept", {out_data, out_dir, out_head, out_tail}, {e.data, e.dir, e.head, e.tail});
        end
      end
    end else begin
      stall_valid = 0;
    end
  end

  task automatic wait_valid(input int maxc);
    for (int i = 0; i < maxc && !out_valid; i++) tick();
    checkOutput("wait_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic wait_drain(input int maxc);
    for (int i = 0; i < maxc && (exp_q.size() != 0 || fifo_q.size() != 0 || out_valid); i++) tick();
    repeat (3) tick();
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_data"}, 64'(out_data), 64'd0);
    checkOutput({tag, "_dir"}, 64'(out_dir), 64'd0);
    checkOutput({tag, "_head_tail"}, {out_head, out_tail}, 64'd0);
    checkOutput({tag, "_pkt_active"}, 64'(pkt_active), 64'd0);
    checkOutput({tag, "_err_orphan"}, 64'(err_orphan), 64'd0);
  endtask

  task automatic push_packet(input logic [31:0] head, input int bodies, input logic [31:0] tail);
    applyStimulus(head);
    for (int b = 0; b < bodies; b++) applyStimulus(32'h0000_0100 + 32'(b));
    applyStimulus(tail);
  endtask

  initial begin
    vec_t vecs[9];
    int   t_rd, t_v, k, pulses;
    int   acc[4];
    int   base_pop, base_acc, base_orph;
    logic [1:0] x;
    logic y;
    int   len;

    vecs[0] = '{flit: 32'hD000_0005, dir: 5'b10000, head: 1'b1, tail: 1'b1};
    vecs[1] = '{flit: 32'hC800_0000, dir: 5'b01000, head: 1'b1, tail: 1'b1};
    vecs[2] = '{flit: 32'hF000_0000, dir: 5'b00010, head: 1'b1, tail: 1'b1};
    vecs[3] = '{flit: 32'hD800_0000, dir: 5'b00100, head: 1'b1, tail: 1'b1};
    vecs[4] = '{flit: 32'hE800_0000, dir: 5'b00010, head: 1'b1, tail: 1'b1};
    vecs[5] = '{flit: 32'hC000_0000, dir: 5'b01000, head: 1'b1, tail: 1'b1};
    vecs[6] = '{flit: 32'h9800_0000, dir: 5'b00100, head: 1'b1, tail: 1'b0};
    vecs[7] = '{flit: 32'hB000_0001, dir: 5'b00010, head: 1'b1, tail: 1'b0};
    vecs[8] = '{flit: 32'h8000_0000, dir: 5'b01000, head: 1'b1, tail: 1'b0};

    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single flit: latency from rd_en to out_valid.
    applyStimulus(32'hD000_0005);
    t_rd = -1;
    t_v  = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_en && t_rd < 0) t_rd = cyc;
      if (out_valid) begin
        t_v = cyc;
        break;
      end
    end
    checkOutput("latency", 64'(t_v - t_rd), 64'd2);
    checkOutput("single_dir", 64'(out_dir), 64'(5'b10000));
    checkOutput("single_head_tail", {out_head, out_tail}, 64'b11);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("single_stays_idle", 64'(pkt_active), 64'd0);
    wait_drain(20);

    // Table of routes and head/tail decode at presentation time.
    for (int i = 0; i < 9; i++) begin
      out_ready = 1'b0;
      applyStimulus(vecs[i].flit);
      if (vecs[i].flit[31:30] == 2'b10) applyStimulus(32'h4000_0000 + 32'(i));
      wait_valid(20);
      checkOutput($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].flit));
      checkOutput($sformatf("vec%0d_dir", i), 64'(out_dir), 64'(vecs[i].dir));
      checkOutput($sformatf("vec%0d_head_tail", i), {out_head, out_tail}, {vecs[i].head, vecs[i].tail});
      out_ready = 1'b1;
      wait_drain(30);
    end

    // Four-flit packet streamed back to back.
    out_ready = 1'b0;
    push_packet(32'hB000_0001, 0, 32'h0000_0002);
    exp_q.delete();
    fifo_q.delete();
    m_active = 0;
    applyStimulus(32'hB000_0001);
    applyStimulus(32'h0000_0002);
    applyStimulus(32'h0000_0003);
    applyStimulus(32'h4000_0004);
    wait_valid(20);
    out_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 20 && k < 4; i++) begin
      if (out_valid && out_ready) begin
        acc[k] = cyc;
        checkOutput($sformatf("burst%0d_pkt_active", k), 64'(pkt_active), 64'(k > 0));
        checkOutput($sformatf("burst%0d_dir", k), 64'(out_dir), 64'(5'b00010));
        k++;
      end
      tick();
    end
    checkOutput("burst_count", 64'(k), 64'd4);
    checkOutput("burst_back_to_back", 64'(acc[3] - acc[0]), 64'd3);
    checkOutput("burst_pkt_active_after", 64'(pkt_active), 64'd0);
    wait_drain(20);

    // Backpressure: queue fills, rd_en stops, head flit held.
    out_ready = 1'b0;
    applyStimulus(32'hB000_0001);
    applyStimulus(32'h0000_0002);
    applyStimulus(32'h0000_0003);
    applyStimulus(32'h4000_0004);
    repeat (8) tick();
    checkOutput("stall_rd_en", 64'(rd_en), 64'd0);
    checkOutput("stall_valid", 64'(out_valid), 64'd1);
    checkOutput("stall_data", 64'(out_data), 64'hB000_0001);
    checkOutput("stall_fifo_left", 64'(fifo_q.size()), 64'd1);
    out_ready = 1'b1;
    wait_drain(30);

    // Orphan body while idle, then a head routed west.
    out_ready = 1'b0;
    applyStimulus(32'h0000_00AA);
    applyStimulus(32'h8800_0000);
    applyStimulus(32'h4000_0000);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (err_orphan) pulses++;
      if (out_valid) break;
    end
    checkOutput("orphan_pulse", 64'(pulses), 64'd1);
    checkOutput("orphan_next_data", 64'(out_data), 64'h8800_0000);
    checkOutput("orphan_next_dir", 64'(out_dir), 64'(5'b01000));
    out_ready = 1'b1;
    wait_drain(30);

    // Reset one cycle after the head of a 4-flit packet is accepted.
    out_ready = 1'b0;
    applyStimulus(32'hB000_0001);
    applyStimulus(32'h0000_0002);
    applyStimulus(32'h0000_0003);
    applyStimulus(32'h4000_0004);
    repeat (6) tick();
    out_ready = 1'b1;
    tick();
    rst = 1'b1;
    exp_q.delete();
    m_active = 0;
    #1;
    check_reset_outputs("midrst");
    out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    applyStimulus(32'hC800_0000);
    wait_valid(20);
    checkOutput("post_rst_data", 64'(out_data), 64'hC800_0000);
    checkOutput("post_rst_dir", 64'(out_dir), 64'(5'b01000));
    checkOutput("post_rst_head_tail", {out_head, out_tail}, 64'b11);
    out_ready = 1'b1;
    wait_drain(20);

    // South-bound packet with out_ready alternating and FIFO kept fed.
    base_pop = popped;
    base_acc = accepted;
    push_packet(32'h9800_0000, 6, 32'h4000_0007);
    push_packet(32'hB000_0010, 3, 32'h4000_0011);
    for (int i = 0; i < 40; i++) begin
      out_ready = cyc[0];
      tick();
    end
    out_ready = 1'b1;
    wait_drain(40);
    checkOutput("alt_pop_vs_accept", 64'(popped - base_pop), 64'(accepted - base_acc));

    // Random packets and stray orphans against the reference model.
    base_pop  = popped;
    base_acc  = accepted;
    base_orph = orphans_seen;
    for (int p = 0; p < 60; p++) begin
      x = 2'($urandom_range(0, 3));
      y = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        applyStimulus({($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00, 30'($urandom)});
      end else begin
        len = $urandom_range(1, 4);
        if (len == 1) begin
          applyStimulus({2'b11, x, y, 27'($urandom)});
        end else begin
          applyStimulus({2'b10, x, y, 27'($urandom)});
          for (int b = 0; b < len - 2; b++) applyStimulus({2'b00, 30'($urandom)});
          applyStimulus({2'b01, 30'($urandom)});
        end
      end
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    for (int i = 0; i < 100; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = 1'b1;
    wait_drain(300);
    checkOutput("rand_conservation", 64'(popped - base_pop),
                64'((accepted - base_acc) + (orphans_seen - base_orph)));
    checkOutput("orphan_total", 64'(orphans_seen), 64'(m_orphans));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/noc_input_port.md
# noc_input_port

Router input stage that drains one async FIFO (8x32, read side) in the router clock domain, buffers flits in a 3-entry local queue and computes the XY route for each packet. It presents flits, with a one-hot output direction, to the switch allocator over a valid/ready handshake. It holds the route for the whole packet until the tail flit leaves. One instance sits between each port's async FIFO and the crossbar of a 2x4 mesh router.

## Interface
- DATA_WIDTH, 32, flit width (matches `DATA_WIDTH)
- LOCAL_X, 0, this router's column, 0..3
- LOCAL_Y, 0, this router's row, 0..1
- clk  in  1  router clock (same as FIFO rd_clk)
- rst  in  1  reset; one clock, reset asynchronous, active-high
- rd_en  out  1  FIFO pop request
- rd_data  in  DATA_WIDTH  FIFO read data, valid the cycle after rd_en
- empty  in  1  FIFO empty flag
- out_valid  out  1  flit available to allocator
- out_ready  in  1  allocator accepts flit this cycle
- out_data  out  DATA_WIDTH  flit
- out_dir  out  5  one-hot route {LOCAL,W,S,E,N} = bits [4:0]
- out_head  out  1  out_data is head or single flit
- out_tail  out  1  out_data is tail or single flit
- pkt_active  out  1  a multi-flit packet is locked
- err_orphan  out  1  one-cycle pulse: body/tail dropped while idle

## Operation
- Flit type = data[31:30]: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single. Head/single dest: dst_x = data[29:28], dst_y = data[27].
- XY route, X first: dst_x>LOCAL_X -> E; dst_x<LOCAL_X -> W; else dst_y>LOCAL_Y -> S; dst_y<LOCAL_Y -> N; else LOCAL. Unsigned compares.
- Fetch: rd_en = !rst && !empty && (count + inflight) < 3. count = queue occupancy (0..3). inflight = registered rd_en from the previous cycle. The queue therefore never overflows.
- Capture: a cycle with inflight=1 writes rd_data into the queue tail, in FIFO order.
- FSM with two states.
  - IDLE: the queue head must be a head/single flit. out_dir = XY(queue head). On a head accept: latch route_reg and go to ACTIVE. On a single accept: stay in IDLE.
  - ACTIVE: out_dir = route_reg. pkt_active = 1. On a tail accept: return to IDLE.
- Orphans:
  - In IDLE, a body/tail flit at the queue head is discarded that cycle. out_valid = 0. err_orphan pulses for 1 cycle.
  - In ACTIVE, a head/single flit at the queue head is forwarded as a body flit on route_reg. The FSM still leaves ACTIVE only on a tail.
- A flit is accepted when out_valid && out_ready. It is popped from the queue that edge.
- Simultaneous pop and capture in one cycle: count is unchanged and order is preserved.
- out_head and out_tail are decoded from the type bits of the queue head. When out_valid=0, out_head, out_tail and out_dir are 0.

## Timing
- Reset values: rd_en=0, out_valid=0, out_data=0, out_dir=0, out_head=0, out_tail=0, pkt_active=0, err_orphan=0. Queue, count, inflight, route_reg and FSM (IDLE) are all cleared.
- Reset asserted mid-packet: all queued and in-flight flits are lost, and the FSM returns to IDLE. The FIFO is reset in the same domain event.
- Latency: rd_en in cycle t, data on rd_data in t+1, written at the end of t+1, out_valid in t+2. The empty-queue path is 2 cycles.
- Throughput: 1 flit/cycle sustained while out_ready=1 and the FIFO is non-empty.
- out_ready=0 with a non-empty queue: out_data, out_dir and out_valid hold stable until accepted. With the FIFO non-empty, the queue fills to 3 and rd_en drops.
- out_ready is not combinationally used by rd_en. The only combinational paths are empty -> rd_en and queue head -> out_dir.

## Test plan
- LOCAL_X=1, LOCAL_Y=0. FIFO holds single flit 32'hD000_0005 (dst 1,0) -> out_valid 2 cycles after rd_en; out_dir=5'b10000, out_head=out_tail=1; FSM stays IDLE.
- Packet head 32'hB000_0001 (dst 3,0), bodies 32'h0000_0002 and 32'h0000_0003, tail 32'h4000_0004, out_ready=1 -> 4 consecutive accepts all with out_dir=5'b00010. pkt_active=1 from the head accept until the tail accept.
- Same packet with out_ready=0 for 6 cycles -> count reaches 3, rd_en=0 after that, out_data stays 32'hB000_0001. On release, all 4 flits are delivered in order with no loss.
- Orphan body 32'h0000_00AA while IDLE -> never valid on the output; err_orphan is a 1-cycle pulse; the following head 32'h8800_0000 (dst 0,1) routes W (5'b01000).
- rst asserted one cycle after the head accept of a 4-flit packet -> all outputs return to 0 and pkt_active=0. After release, a fresh single flit 32'hC800_0000 (dst 0,1) routes W correctly.
- Head to dst (1,1) 32'h9800_0000 -> out_dir=5'b00100 (S). Alternate out_ready 1/0 with continuous FIFO data -> no drop or duplication; accepted count equals popped count.
